axi_arbiter: RTL

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_arbiter.sv
// Two-source AXI arbiter: s0 (instruction fetch, read only) and s1 (load/store) onto one AXI master.
// Define AXI_ARBITER_RR_EN for round-robin read arbitration; default build gives s1 fixed priority.
module axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic                clock,
   input  logic                reset,
   // s0 read
   input  logic                s0_arvalid,
   output logic                s0_arready,
   input  logic [ADDR_W-1:0]   s0_araddr,
   output logic                s0_rvalid,
   input  logic                s0_rready,
   output logic [DATA_W-1:0]   s0_rdata,
   output logic [1:0]          s0_rresp,
   // s1 read
   input  logic                s1_arvalid,
   output logic                s1_arready,
   input  logic [ADDR_W-1:0]   s1_araddr,
   input  logic [2:0]          s1_arsize,
   output logic                s1_rvalid,
   input  logic                s1_rready,
   output logic [DATA_W-1:0]   s1_rdata,
   output logic [1:0]          s1_rresp,
   // s1 write
   input  logic                s1_awvalid,
   output logic                s1_awready,
   input  logic [ADDR_W-1:0]   s1_awaddr,
   input  logic [2:0]          s1_awsize,
   input  logic                s1_wvalid,
   output logic                s1_wready,
   input  logic [DATA_W-1:0]   s1_wdata,
   input  logic [DATA_W/8-1:0] s1_wstrb,
   output logic                s1_bvalid,
   input  logic                s1_bready,
   output logic [1:0]          s1_bresp,
   // master read address
   output logic                m_arvalid,
   input  logic                m_arready,
   output logic [3:0]          m_arid,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [7:0]          m_arlen,
   output logic [2:0]          m_arsize,
   output logic [1:0]          m_arburst,
   // master read data
   input  logic                m_rvalid,
   output logic                m_rready,
   input  logic [3:0]          m_rid,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rlast,
   // master write address
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [3:0]          m_awid,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [7:0]          m_awlen,
   output logic [2:0]          m_awsize,
   output logic [1:0]          m_awburst,
   // master write data
   output logic                m_wvalid,
   input  logic                m_wready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wlast,
   // master write response
   input  logic                m_bvalid,
   output logic                m_bready,
   input  logic [3:0]          m_bid,
   input  logic [1:0]          m_bresp
);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   rd_state_t             rd_state_r;
   rd_state_t             rd_next_s;
   wr_state_t             wr_state_r;
   wr_state_t             wr_next_s;

   logic                  rd_gnt_r;
   logic [ADDR_W-1:0]     ar_addr_r;
   logic [2:0]            ar_size_r;
   logic                  gnt_s1_s;
   logic                  rd_req_s;
   logic                  rd_rready_s;

   logic [ADDR_W-1:0]     aw_addr_r;
   logic [2:0]            aw_size_r;
   logic [DATA_W-1:0]     w_data_r;
   logic [DATA_W/8-1:0]   w_strb_r;
   logic                  wr_take_s;

   // Single-beat reads: response id and last flag carry no information here.
   logic                  unused_s;
   assign unused_s = ^{m_rid, m_rlast, m_bid};

   assign rd_req_s    = s0_arvalid | s1_arvalid;
   assign rd_rready_s = rd_gnt_r ? s1_rready : s0_rready;
   assign wr_take_s   = s1_awvalid & s1_wvalid;

`ifdef AXI_ARBITER_RR_EN
   logic                  rr_r;

   // Round-robin pick: rr_r = 0 favours s0, 1 favours s1.
   always_comb begin
      gnt_s1_s = 1'b0;
      if (s0_arvalid && s1_arvalid) begin
         gnt_s1_s = rr_r;
      end else begin
         gnt_s1_s = s1_arvalid;
      end
   end

   // Pointer moves to the source that was not just granted.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_r <= 1'b0;
      end else if (rd_state_r == R_IDLE && rd_req_s) begin
         rr_r <= ~gnt_s1_s;
      end else begin
         rr_r <= rr_r;
      end
   end
`else
   // Fixed priority: load/store always beats instruction fetch.
   always_comb begin
      gnt_s1_s = s1_arvalid;
   end
`endif

   // Read FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_state_r <= R_IDLE;
      end else begin
         rd_state_r <= rd_next_s;
      end
   end

   // Read FSM next state.
   always_comb begin
      rd_next_s = rd_state_r;
      case (rd_state_r)
         R_IDLE: begin
            if (rd_req_s) rd_next_s = R_ADDR;
            else          rd_next_s = R_IDLE;
         end
         R_ADDR: begin
            if (m_arready) rd_next_s = R_DATA;
            else           rd_next_s = R_ADDR;
         end
         R_DATA: begin
            if (m_rvalid && rd_rready_s) rd_next_s = R_IDLE;
            else                         rd_next_s = R_DATA;
         end
         default: rd_next_s = R_IDLE;
      endcase
   end

   // Read request capture; the address stays put until the response completes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_gnt_r  <= 1'b0;
         ar_addr_r <= {ADDR_W{1'b0}};
         ar_size_r <= 3'b000;
      end else if (rd_state_r == R_IDLE && rd_req_s) begin
         rd_gnt_r  <= gnt_s1_s;
         ar_addr_r <= gnt_s1_s ? s1_araddr : s0_araddr;
         ar_size_r <= gnt_s1_s ? s1_arsize : 3'b010;
      end else begin
         rd_gnt_r  <= rd_gnt_r;
         ar_addr_r <= ar_addr_r;
         ar_size_r <= ar_size_r;
      end
   end

   // Read FSM outputs; responses reach the granted source only.
   always_comb begin
      s0_arready = 1'b0;
      s1_arready = 1'b0;
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      s0_rvalid  = 1'b0;
      s1_rvalid  = 1'b0;
      s0_rdata   = {DATA_W{1'b0}};
      s1_rdata   = {DATA_W{1'b0}};
      s0_rresp   = 2'b00;
      s1_rresp   = 2'b00;
      case (rd_state_r)
         R_IDLE: begin
            s0_arready = s0_arvalid & ~gnt_s1_s;
            s1_arready = gnt_s1_s;
         end
         R_ADDR: begin
            m_arvalid = 1'b1;
         end
         R_DATA: begin
            m_rready = rd_rready_s;
            if (rd_gnt_r) begin
               s1_rvalid = m_rvalid;
               s1_rdata  = m_rdata;
               s1_rresp  = m_rresp;
            end else begin
               s0_rvalid = m_rvalid;
               s0_rdata  = m_rdata;
               s0_rresp  = m_rresp;
            end
         end
         default: begin
            m_arvalid = 1'b0;
         end
      endcase
   end

   assign m_arid    = {3'b000, rd_gnt_r};
   assign m_araddr  = ar_addr_r;
   assign m_arlen   = 8'd0;
   assign m_arsize  = ar_size_r;
   assign m_arburst = 2'b01;

   // Write FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_state_r <= W_IDLE;
      end else begin
         wr_state_r <= wr_next_s;
      end
   end

   // Write FSM next state; address and data must be accepted in the same cycle.
   always_comb begin
      wr_next_s = wr_state_r;
      case (wr_state_r)
         W_IDLE: begin
            if (wr_take_s) wr_next_s = W_REQ;
            else           wr_next_s = W_IDLE;
         end
         W_REQ: begin
            if (m_awready && m_wready) wr_next_s = W_RESP;
            else                       wr_next_s = W_REQ;
         end
         W_RESP: begin
            if (m_bvalid && s1_bready) wr_next_s = W_IDLE;
            else                       wr_next_s = W_RESP;
         end
         default: wr_next_s = W_IDLE;
      endcase
   end

   // Write request capture; held until the next write is accepted.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         aw_addr_r <= {ADDR_W{1'b0}};
         aw_size_r <= 3'b000;
         w_data_r  <= {DATA_W{1'b0}};
         w_strb_r  <= {(DATA_W/8){1'b0}};
      end else if (wr_state_r == W_IDLE && wr_take_s) begin
         aw_addr_r <= s1_awaddr;
         aw_size_r <= s1_awsize;
         w_data_r  <= s1_wdata;
         w_strb_r  <= s1_wstrb;
      end else begin
         aw_addr_r <= aw_addr_r;
         aw_size_r <= aw_size_r;
         w_data_r  <= w_data_r;
         w_strb_r  <= w_strb_r;
      end
   end

   // Write FSM outputs.
   always_comb begin
      s1_awready = 1'b0;
      s1_wready  = 1'b0;
      m_awvalid  = 1'b0;
      m_wvalid   = 1'b0;
      m_wlast    = 1'b0;
      m_bready   = 1'b0;
      s1_bvalid  = 1'b0;
      s1_bresp   = 2'b00;
      case (wr_state_r)
         W_IDLE: begin
            s1_awready = wr_take_s;
            s1_wready  = wr_take_s;
         end
         W_REQ: begin
            m_awvalid = 1'b1;
            m_wvalid  = 1'b1;
            m_wlast   = 1'b1;
         end
         W_RESP: begin
            m_bready  = s1_bready;
            s1_bvalid = m_bvalid;
            s1_bresp  = m_bresp;
         end
         default: begin
            m_awvalid = 1'b0;
         end
      endcase
   end

   assign m_awid    = 4'd1;
   assign m_awaddr  = aw_addr_r;
   assign m_awlen   = 8'd0;
   assign m_awsize  = aw_size_r;
   assign m_awburst = 2'b01;
   assign m_wdata   = w_data_r;
   assign m_wstrb   = w_strb_r;

endmodule
